// File: rtl/evt_strobe_gen.sv
// evt_strobe_gen: periodic single-cycle event strobes, either a fixed-length burst or free-running.
// Define EVT_STROBE_GEN_PAUSE_EN to add the pause_in port that freezes a run in place.
module evt_strobe_gen #(
   parameter int PERIOD_W = 17,
   parameter int BURST_W  = 27
) (
   input  logic                clk_in,
   input  logic                rst_in,
   // cfg handshake: a transfer happens on an edge where cfg_valid_in and cfg_ready_out are both
   // high; ready is high only in IDLE, and valid may be raised or dropped at any time.
   input  logic                cfg_valid_in,
   output logic                cfg_ready_out,
   input  logic [PERIOD_W-1:0] cfg_period_in,
   input  logic [BURST_W-1:0]  cfg_burst_in,
   input  logic                start_in,
   input  logic                stop_in,
`ifdef EVT_STROBE_GEN_PAUSE_EN
   input  logic                pause_in,
`endif
   output logic                evt_out,
   output logic                busy_out,
   output logic                done_out,
   output logic [BURST_W-1:0]  evt_idx_out
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state_q;
   logic [PERIOD_W-1:0] period_q;
   logic [BURST_W-1:0]  burst_q;
   logic [PERIOD_W-1:0] ph_q;
   logic [BURST_W-1:0]  cnt_q;
   logic                evt_q;
   logic                done_q;

   logic [PERIOD_W-1:0] ph_d;
   logic [BURST_W-1:0]  cnt_d;
   logic                pause_w;

`ifdef EVT_STROBE_GEN_PAUSE_EN
   assign pause_w = pause_in;
`else
   assign pause_w = 1'b0;
`endif

   // Phase wraps at period_q-1, so a period of 1 keeps ph at 0 and strobes every cycle.
   always_comb begin
      ph_d  = (ph_q == period_q - 1'b1) ? '0 : ph_q + 1'b1;
      cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q  <= ST_IDLE;
         period_q <= PERIOD_W'(1);
         burst_q  <= BURST_W'(1);
         ph_q     <= '0;
         cnt_q    <= '0;
         evt_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               evt_q  <= 1'b0;
               done_q <= 1'b0;
               if (cfg_valid_in) begin
                  period_q <= (cfg_period_in == '0) ? PERIOD_W'(1) : cfg_period_in;
                  burst_q  <= cfg_burst_in;
               end
               if (start_in) begin
                  ph_q    <= '0;
                  cnt_q   <= '0;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               done_q <= 1'b0;
               if (stop_in) begin
                  // Stop beats a pulse that would be due on this same edge.
                  evt_q   <= 1'b0;
                  state_q <= ST_DONE;
               end else if (pause_w) begin
                  evt_q <= 1'b0;
               end else begin
                  evt_q <= (ph_q == '0);
                  ph_q  <= ph_d;
                  if (ph_q == '0) begin
                     cnt_q <= cnt_d;
                     if ((burst_q != '0) && (cnt_d == burst_q)) begin
                        state_q <= ST_DONE;
                     end
                  end
               end
            end
            ST_DONE: begin
               evt_q   <= 1'b0;
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign cfg_ready_out = (state_q == ST_IDLE);
   assign busy_out      = (state_q == ST_RUN);
   assign evt_out       = evt_q;
   assign done_out      = done_q;
   assign evt_idx_out   = cnt_q;

endmodule

// File: tb/tb_evt_strobe_gen.sv
// tb_evt_strobe_gen: randomized and directed scenarios for evt_strobe_gen against a behavioural
// model that counts un-paused RUN edges and emits a pulse on every P-th one.
module tb_evt_strobe_gen;

   localparam int PW = 17;
   localparam int BW = 27;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [PW-1:0] cfg_period;
   logic [BW-1:0] cfg_burst;
   logic          start;
   logic          stop;
`ifdef EVT_STROBE_GEN_PAUSE_EN
   logic          pause;
`endif
   logic          evt;
   logic          busy;
   logic          done;
   logic [BW-1:0] evt_idx;

   int n_checks = 0;
   int n_pass   = 0;
   int m_per    = 1;   // configuration the block is expected to hold
   int m_burst  = 1;

   evt_strobe_gen #(.PERIOD_W(PW), .BURST_W(BW)) dut (
      .clk_in        (clk),
      .rst_in        (rst_n),
      .cfg_valid_in  (cfg_valid),
      .cfg_ready_out (cfg_ready),
      .cfg_period_in (cfg_period),
      .cfg_burst_in  (cfg_burst),
      .start_in      (start),
      .stop_in       (stop),
`ifdef EVT_STROBE_GEN_PAUSE_EN
      .pause_in      (pause),
`endif
      .evt_out       (evt),
      .busy_out      (busy),
      .done_out      (done),
      .evt_idx_out   (evt_idx)
   );

   always #5 clk = ~clk;

   // One run from start to two cycles past its end, checking every cycle against the model.
   // Inputs are driven at the falling edge; stop_j and the pause window are in edges after start.
   task automatic do_run(input bit send_cfg, input int per, input int bur, input int stop_j,
                         input int pz_lo, input int pz_hi, input bit junk, output int n_pulses);
      int  P, B, m, pc, end_j, j;
      bit  running, exp_evt, exp_done;
      n_checks++;
      if (cfg_ready !== 1'b1) $display("FAIL run_start_ready got=%0b exp=1", cfg_ready);
      else n_pass++;
      if (send_cfg) begin
         cfg_valid  = 1'b1;
         cfg_period = PW'(per);
         cfg_burst  = BW'(bur);
         m_per      = (per == 0) ? 1 : per;
         m_burst    = bur;
      end
      start = 1'b1;
      P = m_per; B = m_burst; m = 0; pc = 0; end_j = -1; running = 1'b1; j = 0;
      @(posedge clk);
      @(negedge clk);
      cfg_valid = 1'b0;
      start     = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || evt !== 1'b0 || done !== 1'b0 || evt_idx !== '0 || cfg_ready !== 1'b0)
         $display("FAIL run_edge0 got busy=%0b evt=%0b done=%0b idx=%0d rdy=%0b exp 1/0/0/0/0",
                  busy, evt, done, evt_idx, cfg_ready);
      else n_pass++;
      while (end_j < 0 || j < end_j + 2) begin
         if (j > 2000) begin
            n_checks++;
            $display("FAIL run_timeout got=no_end exp=end_within_2000");
            break;
         end
         stop = (j + 1 == stop_j);
`ifdef EVT_STROBE_GEN_PAUSE_EN
         pause = (j + 1 >= pz_lo) && (j + 1 <= pz_hi);
`endif
         if (junk && running) begin
            start      = 1'($urandom_range(0, 1));
            cfg_valid  = 1'($urandom_range(0, 1));
            cfg_period = PW'($urandom_range(0, 9));
            cfg_burst  = BW'($urandom_range(0, 9));
         end else begin
            start     = 1'b0;
            cfg_valid = 1'b0;
         end
         @(posedge clk);
         j++;
         exp_evt = 1'b0;
         if (running) begin
            if (j == stop_j) begin
               running = 1'b0;
               end_j   = j;
            end else if (!(j >= pz_lo && j <= pz_hi)) begin
               if (m % P == 0) begin
                  exp_evt = 1'b1;
                  pc++;
               end
               m++;
               if (exp_evt && B != 0 && pc == B) begin
                  running = 1'b0;
                  end_j   = j;
               end
            end
         end
         exp_done = (end_j >= 0) && (j == end_j + 1);
         @(negedge clk);
         n_checks++;
         if (evt !== exp_evt) $display("FAIL run_evt j=%0d got=%0b exp=%0b", j, evt, exp_evt);
         else n_pass++;
         n_checks++;
         if (done !== exp_done) $display("FAIL run_done j=%0d got=%0b exp=%0b", j, done, exp_done);
         else n_pass++;
         n_checks++;
         if (busy !== running) $display("FAIL run_busy j=%0d got=%0b exp=%0b", j, busy, running);
         else n_pass++;
         n_checks++;
         if (evt_idx !== BW'(pc)) $display("FAIL run_idx j=%0d got=%0d exp=%0d", j, evt_idx, pc);
         else n_pass++;
         if (running || (end_j >= 0 && j == end_j + 2)) begin
            n_checks++;
            if (cfg_ready !== !running)
               $display("FAIL run_ready j=%0d got=%0b exp=%0b", j, cfg_ready, !running);
            else n_pass++;
         end
      end
      stop      = 1'b0;
      start     = 1'b0;
      cfg_valid = 1'b0;
`ifdef EVT_STROBE_GEN_PAUSE_EN
      pause     = 1'b0;
`endif
      n_pulses  = pc;
   endtask

   task automatic test_reset();
      n_checks++;
      if (evt !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || evt_idx !== '0 || cfg_ready !== 1'b1)
         $display("FAIL reset_outputs got evt=%0b busy=%0b done=%0b idx=%0d rdy=%0b exp 0/0/0/0/1",
                  evt, busy, done, evt_idx, cfg_ready);
      else n_pass++;
   endtask

   task automatic test_burst_p3_b4();
      int np;
      do_run(1'b1, 3, 4, -1, -1, -2, 1'b0, np);
      n_checks++;
      if (evt_idx !== BW'(4)) $display("FAIL burst_p3_b4_idx got=%0d exp=4", evt_idx);
      else n_pass++;
   endtask

   task automatic test_period_zero();
      int np;
      do_run(1'b1, 0, 5, -1, -1, -2, 1'b0, np);
      n_checks++;
      if (evt_idx !== BW'(5) || cfg_ready !== 1'b1)
         $display("FAIL period_zero got idx=%0d rdy=%0b exp idx=5 rdy=1", evt_idx, cfg_ready);
      else n_pass++;
   endtask

   task automatic test_stop_on_pulse();
      int np;
      do_run(1'b1, 4, 0, 9, -1, -2, 1'b0, np);
      n_checks++;
      if (evt_idx !== BW'(2)) $display("FAIL stop_on_pulse_idx got=%0d exp=2", evt_idx);
      else n_pass++;
   endtask

   task automatic test_cfg_during_run();
      int np;
      do_run(1'b1, 2, 3, -1, -1, -2, 1'b1, np);
      do_run(1'b0, 0, 0, -1, -1, -2, 1'b0, np);
      n_checks++;
      if (evt_idx !== BW'(3)) $display("FAIL cfg_locked_idx got=%0d exp=3", evt_idx);
      else n_pass++;
      do_run(1'b1, 5, 2, -1, -1, -2, 1'b0, np);
      n_checks++;
      if (evt_idx !== BW'(2)) $display("FAIL cfg_with_start_idx got=%0d exp=2", evt_idx);
      else n_pass++;
   endtask

   task automatic test_idle_ignores_stop();
      for (int i = 0; i < 4; i++) begin
         stop = 1'($urandom_range(0, 1));
         @(negedge clk);
         n_checks++;
         if (busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1)
            $display("FAIL idle_stop got busy=%0b done=%0b rdy=%0b exp 0/0/1", busy, done, cfg_ready);
         else n_pass++;
      end
      stop = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      int  np;
      bit  saw_done;
      cfg_valid  = 1'b1;
      cfg_period = PW'(3);
      cfg_burst  = BW'(8);
      start      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cfg_valid = 1'b0;
      start     = 1'b0;
      repeat (4) @(negedge clk);
      n_checks++;
      if (evt !== 1'b1) $display("FAIL rst_mid_second_pulse got=%0b exp=1", evt);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (evt !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || evt_idx !== '0 || cfg_ready !== 1'b1)
         $display("FAIL rst_mid_async got evt=%0b busy=%0b done=%0b idx=%0d rdy=%0b exp 0/0/0/0/1",
                  evt, busy, done, evt_idx, cfg_ready);
      else n_pass++;
      @(negedge clk);
      rst_n   = 1'b1;
      m_per   = 1;
      m_burst = 1;
      saw_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done !== 1'b0) saw_done = 1'b1;
      end
      n_checks++;
      if (saw_done) $display("FAIL rst_mid_no_done got=1 exp=0");
      else n_pass++;
      do_run(1'b0, 0, 0, -1, -1, -2, 1'b0, np);
      n_checks++;
      if (evt_idx !== BW'(1)) $display("FAIL rst_defaults_idx got=%0d exp=1", evt_idx);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int np;
      do_run(1'b1, 1, 2, -1, -1, -2, 1'b0, np);
      do_run(1'b1, 2, 2, -1, -1, -2, 1'b0, np);
      n_checks++;
      if (evt_idx !== BW'(2)) $display("FAIL back_to_back_idx got=%0d exp=2", evt_idx);
      else n_pass++;
   endtask

   task automatic test_random();
      int np, per, bur, ep, eb, sj, plo, phi;
      bit sc;
      for (int it = 0; it < 25; it++) begin
         sc  = 1'($urandom_range(0, 1));
         per = $urandom_range(0, 5);
         bur = $urandom_range(0, 6);
         ep  = sc ? ((per == 0) ? 1 : per) : m_per;
         eb  = sc ? bur : m_burst;
         sj  = -1;
         if (eb == 0) sj = $urandom_range(1, 30);
         else if ($urandom_range(0, 2) == 0) sj = $urandom_range(1, 1 + (eb - 1) * ep);
         plo = -1;
         phi = -2;
`ifdef EVT_STROBE_GEN_PAUSE_EN
         if ($urandom_range(0, 1) == 1) begin
            plo = $urandom_range(1, 8);
            phi = plo + $urandom_range(0, 5);
         end
`endif
         do_run(sc, per, bur, sj, plo, phi, 1'($urandom_range(0, 1)), np);
      end
   endtask

`ifdef EVT_STROBE_GEN_PAUSE_EN
   task automatic test_pause();
      int np;
      do_run(1'b1, 2, 3, -1, 3, 7, 1'b0, np);
      n_checks++;
      if (evt_idx !== BW'(3)) $display("FAIL pause_total_idx got=%0d exp=3", evt_idx);
      else n_pass++;
   endtask
`endif

   initial begin
      rst_n      = 1'b0;
      cfg_valid  = 1'b0;
      cfg_period = '0;
      cfg_burst  = '0;
      start      = 1'b0;
      stop       = 1'b0;
`ifdef EVT_STROBE_GEN_PAUSE_EN
      pause      = 1'b0;
`endif
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_burst_p3_b4();
      test_period_zero();
      test_stop_on_pulse();
      test_cfg_during_run();
      test_idle_ignores_stop();
      test_reset_mid_run();
      test_back_to_back();
`ifdef EVT_STROBE_GEN_PAUSE_EN
      test_pause();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/evt_strobe_gen.md
# evt_strobe_gen

Programmable event-strobe generator: emits single-cycle `evt_out` pulses at a configurable period, for a configurable burst length or free-running. It is the producer side of the event-counting path and drives an `evt_in`-style input of a downstream counter. Typical uses are pixel, line and frame strobes and test stimulus in the camera pipeline.

## Interface
Parameters:
- `PERIOD_W`, default 17: width of the period register. Matches the counter's max-count width.
- `BURST_W`, default 27: width of the burst length and of the event index. Matches the counter's count width.

Ports:
- `clk_in`  input  1  system clock; all logic is on the rising edge.
- `rst_in`  input  1  asynchronous, active-low reset.
- `cfg_valid_in`  input  1  configuration offer.
- `cfg_ready_out`  output  1  configuration accepted this cycle when both valid and ready are high.
- `cfg_period_in`  input  PERIOD_W  cycles between pulses; 0 is treated as 1.
- `cfg_burst_in`  input  BURST_W  number of pulses per run; 0 means free-running.
- `start_in`  input  1  begin a run; sampled only in IDLE.
- `stop_in`  input  1  abort the current run; sampled only in RUN.
- `evt_out`  output  1  event strobe, one cycle wide (continuous high when the period is 1).
- `busy_out`  output  1  high while in RUN.
- `done_out`  output  1  one-cycle pulse at the end of every run, whether completed or aborted.
- `evt_idx_out`  output  BURST_W  number of pulses emitted in the current or most recent run.

## Operation
- Registers: `period_q` (reset 1), `burst_q` (reset 1), phase counter `ph` (reset 0), emitted count `cnt` (reset 0).
- Reset values of outputs: `evt_out`=0, `done_out`=0, `busy_out`=0, `evt_idx_out`=0. `cfg_ready_out`=1, because reset enters IDLE.
- States:
  - IDLE: `cfg_ready_out`=1. A configuration handshake loads `period_q` (a value of 0 is stored as 1) and `burst_q`. On `start_in`: `ph`←0, `cnt`←0, go to RUN.
  - RUN: at each edge, `evt_out`←(`ph`==0), `ph`←(`ph`==`period_q`−1) ? 0 : `ph`+1, and `cnt`←`cnt`+1 when a pulse is issued. When the pulse just issued makes `cnt`==`burst_q` (with `burst_q`≠0), go to DONE.
  - DONE: held for one cycle. `evt_out`←0, `done_out`←1, then return to IDLE.
- `cfg_ready_out`=0 outside IDLE. Configuration cannot change during a run.
- Configuration handshake and `start_in` in the same IDLE cycle: the new configuration governs this run.
- `start_in` in RUN or DONE is ignored. `stop_in` in IDLE is ignored.
- `stop_in` in RUN: at the next edge the block goes to DONE and no pulse is issued on that edge, even if `ph`==0. Stop wins over a simultaneous event.
- Free-running mode (`burst_q`=0): the run ends only on `stop_in`. `cnt` wraps from 2^BURST_W−1 to 0 without ending the run.
- `evt_idx_out`=`cnt`. It holds after the run and clears on the next start.
- Reset asserted mid-run: all registers return to their reset values immediately (asynchronously), with no `done_out` pulse.

## Timing
- `start_in` sampled high at edge k: `busy_out` is high from k. The first `evt_out` is high for the cycle after edge k+1.
- Later pulses occur at edges k+1+n·P, where P=`period_q`.
- With burst B: the last pulse is at edge k+1+(B−1)·P. `done_out` is high for the single following cycle, with `busy_out` low and `evt_out` low. The block is back in IDLE, with `cfg_ready_out` high, one cycle later.
- Stop: `stop_in` sampled at edge s. `done_out` is high in the cycle after edge s+1. `evt_out` is low from s.
- Earliest restart after completion: `start_in` may be sampled on the first cycle back in IDLE.

## Configuration
- `EVT_STROBE_GEN_PAUSE_EN` defined: adds the input port `pause_in` (1 bit).
  - While `pause_in` is high in RUN, `ph` and `cnt` freeze and `evt_out` is 0.
  - A pulse due during a pause is issued on the first edge after `pause_in` falls.
  - `stop_in` still takes effect while paused.
- `EVT_STROBE_GEN_PAUSE_EN` undefined: the `pause_in` port is absent and behaviour is exactly as described above.

## Test plan
- Period 3, burst 4, start at edge 10: pulses at edges 11, 14, 17, 20; `done_out` in the cycle after edge 21; `evt_idx_out`=4.
- Period 0 (treated as 1), burst 5: `evt_out` high for 5 consecutive cycles, then one `done_out` cycle, then `cfg_ready_out`=1.
- Period 4, burst 0, `stop_in` at the same edge a pulse is due: no pulse on that edge, one `done_out` pulse, `evt_idx_out` holds the count so far.
- Configuration offered during RUN: not accepted (`cfg_ready_out`=0). The following run still uses the old period. Configuration plus `start_in` in the same IDLE cycle uses the new values.
- Reset asserted during the 2nd pulse of a burst of 8: all outputs 0 within the same cycle, no `done_out`; `period_q`=1 and `burst_q`=1 after release.
- `EVT_STROBE_GEN_PAUSE_EN`, period 2, burst 3: pause for 5 cycles spanning a due pulse; that pulse is deferred to the first edge after release; total pulses still 3.
